// File: rtl/axi_stream_dw_upsizer_pkg.sv
// Default AXI-Stream struct types for the 8->64 upsizer and its configuration helper.
// Zero-width sideband fields are carried as single-bit fields.
package axi_stream_dw_upsizer_pkg;

  localparam int unsigned DefDataWidthIn  = 8;
  localparam int unsigned DefDataWidthOut = 64;

  typedef struct packed {
    logic [DefDataWidthIn-1:0]     data;
    logic [DefDataWidthIn/8-1:0]   strb;
    logic [DefDataWidthIn/8-1:0]   keep;
    logic                          last;
    logic [0:0]                    id;
    logic [0:0]                    dest;
    logic [0:0]                    user;
  } axis_in_t;

  typedef struct packed {
    logic [DefDataWidthOut-1:0]    data;
    logic [DefDataWidthOut/8-1:0]  strb;
    logic [DefDataWidthOut/8-1:0]  keep;
    logic                          last;
    logic [0:0]                    id;
    logic [0:0]                    dest;
    logic [0:0]                    user;
  } axis_out_t;

  typedef struct packed {
    axis_in_t t;
    logic     tvalid;
  } axis_in_req_t;

  typedef struct packed {
    axis_out_t t;
    logic      tvalid;
  } axis_out_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;

  function automatic bit width_cfg_ok(input int unsigned dw_in, input int unsigned dw_out);
    return (dw_in > 0) && (dw_out > dw_in) && ((dw_out % dw_in) == 0);
  endfunction

  function automatic int unsigned field_width(input int unsigned w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/axi_stream_dw_upsizer.sv
// AXI-Stream width upsizer: packs DataWidthOut/DataWidthIn narrow beats little-endian
// into one registered wide word; early tlast or a tid/tdest change closes a word early.
module axi_stream_dw_upsizer
  import axi_stream_dw_upsizer_pkg::*;
#(
  parameter int unsigned DataWidthIn  = 8,
  parameter int unsigned DataWidthOut = 64,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 0,
  parameter type axi_stream_in_req_t  = axis_in_req_t,
  parameter type axi_stream_in_rsp_t  = axis_rsp_t,
  parameter type axi_stream_out_req_t = axis_out_req_t,
  parameter type axi_stream_out_rsp_t = axis_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_in_req_t  in_req_i,
  output axi_stream_in_rsp_t  in_rsp_o,
  output axi_stream_out_req_t out_req_o,
  input  axi_stream_out_rsp_t out_rsp_i
);

  localparam int unsigned N            = DataWidthOut / DataWidthIn;
  localparam int unsigned CounterWidth = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned StrbIn       = DataWidthIn / 8;

  if (!width_cfg_ok(DataWidthIn, DataWidthOut) ||
      ($bits(in_req_i.t.id)   != field_width(IdWidth))   ||
      ($bits(in_req_i.t.dest) != field_width(DestWidth)) ||
      ($bits(in_req_i.t.user) != field_width(UserWidth))) begin : g_bad_cfg
    $fatal(1, "axi_stream_dw_upsizer: illegal width configuration");
  end

  logic [CounterWidth-1:0] cnt_q;
  axi_stream_out_req_t     acc_q;
  axi_stream_out_req_t     out_q;
  axi_stream_out_req_t     merged_s;
  axi_stream_out_req_t     flush_word_s;
  logic                    mismatch_s;
  logic                    out_free_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    complete_s;
  logic                    flush_s;

  // Handshake decode: a sideband change against a partial word stalls input and forces a flush.
  always_comb begin
    mismatch_s = 1'b0;
    if (in_req_i.tvalid && (cnt_q != '0)) begin
      mismatch_s = (in_req_i.t.id != acc_q.t.id) || (in_req_i.t.dest != acc_q.t.dest);
    end else begin
      mismatch_s = 1'b0;
    end
    out_free_s = !out_q.tvalid || out_rsp_i.tready;
    in_ready_s = out_free_s && !mismatch_s;
    accept_s   = in_req_i.tvalid && in_ready_s;
    complete_s = accept_s && ((cnt_q == CounterWidth'(N - 1)) || in_req_i.t.last);
    flush_s    = mismatch_s && out_free_s;
  end

  // Word candidates: accumulator with the incoming beat merged into lane cnt_q, and the bare flush word.
  always_comb begin
    merged_s = acc_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CounterWidth'(k)) begin
        merged_s.t.data[k*DataWidthIn +: DataWidthIn] = in_req_i.t.data;
        merged_s.t.strb[k*StrbIn +: StrbIn]           = in_req_i.t.strb;
        merged_s.t.keep[k*StrbIn +: StrbIn]           = in_req_i.t.keep;
      end else begin
        merged_s.t.data[k*DataWidthIn +: DataWidthIn] = acc_q.t.data[k*DataWidthIn +: DataWidthIn];
      end
    end
    // Sideband of a word is taken from its first beat only.
    if (cnt_q == '0) begin
      merged_s.t.id   = in_req_i.t.id;
      merged_s.t.dest = in_req_i.t.dest;
      merged_s.t.user = in_req_i.t.user;
    end else begin
      merged_s.t.id   = acc_q.t.id;
    end
    merged_s.t.last = in_req_i.t.last;
    merged_s.tvalid = 1'b1;

    flush_word_s        = acc_q;
    flush_word_s.t.last = 1'b0;
    flush_word_s.tvalid = 1'b1;
  end

  // Output register, partial-word accumulator and lane counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (complete_s) begin
        out_q <= merged_s;
      end else if (flush_s) begin
        out_q <= flush_word_s;
      end else if (out_rsp_i.tready) begin
        out_q.tvalid <= 1'b0;
      end else begin
        out_q <= out_q;
      end

      if (complete_s || flush_s) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (accept_s) begin
        acc_q <= merged_s;
        cnt_q <= cnt_q + CounterWidth'(1);
      end else begin
        acc_q <= acc_q;
        cnt_q <= cnt_q;
      end
    end
  end

  // Port mapping.
  always_comb begin
    in_rsp_o        = '0;
    in_rsp_o.tready = in_ready_s;
    out_req_o       = out_q;
  end

endmodule
